// File: rtl/router_input_fifo.sv
// router_input_fifo: first-word-fall-through flit buffer for one router input port.
// Define ROUTER_INPUT_FIFO_ERR_EN to add sticky ovf/udf error flags.
module router_input_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  parameter int PTR_W      = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] Data_in,
  input  logic                  write,
  output logic                  full,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  input  logic                  read,
  output logic [PTR_W:0]        count
`ifdef ROUTER_INPUT_FIFO_ERR_EN
  ,
  output logic                  ovf,
  output logic                  udf
`endif
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0] count_q, count_d;
  logic rd_en, wr_en;
  always_comb begin
    empty    = count_q == '0;
    full     = count_q == (PTR_W+1)'(DEPTH);
    rd_en    = read & ~empty;
    // a pop at full frees the slot the incoming flit needs
    wr_en    = write & (~full | rd_en);
    rd_ptr_d = rd_en ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    count_d  = count_q + (PTR_W+1)'(wr_en) - (PTR_W+1)'(rd_en);
    Data_out = empty ? '0 : mem_q[rd_ptr_q];
    count    = count_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_en & ~rst) mem_q[wr_ptr_q] <= Data_in;
  end
`ifdef ROUTER_INPUT_FIFO_ERR_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      ovf <= ovf | (write & full & ~read);
      udf <= udf | (read & empty);
    end
  end
`endif
endmodule

// File: tb/tb_router_input_fifo.sv
// tb_router_input_fifo: directed plus randomized scoreboard bench for router_input_fifo.
module tb_router_input_fifo;
  localparam int DW = 8;
  localparam int DEPTH = 4;
  localparam int PW = 2;
  logic clk = 1'b0;
  logic rst, write, read;
  logic [DW-1:0] Data_in, Data_out;
  logic full, empty;
  logic [PW:0] count;
`ifdef ROUTER_INPUT_FIFO_ERR_EN
  logic ovf, udf;
  bit e_ovf, e_udf;
`endif
  int checks = 0;
  int failures = 0;
  int occ = 0;
  logic [DW-1:0] exp_q[$];

  router_input_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PTR_W(PW)) dut (
    .clk(clk), .rst(rst), .Data_in(Data_in), .write(write), .full(full),
    .Data_out(Data_out), .empty(empty), .read(read), .count(count)
`ifdef ROUTER_INPUT_FIFO_ERR_EN
    , .ovf(ovf), .udf(udf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // monitor: a presented head flit that is popped must match the scoreboard head
  always @(negedge clk) begin
    if (rst === 1'b0 && read === 1'b1 && empty === 1'b0) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected: got %0h expected nothing", Data_out);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (Data_out !== e) begin
          failures++;
          $display("FAIL pop_data: got %0h expected %0h at %0t", Data_out, e, $time);
        end
      end
    end
  end

  // apply one cycle of stimulus, update the reference queue, then check post-edge state
  task automatic cycle(input bit rs, input bit w, input logic [DW-1:0] d, input bit r);
    bit ra, wa;
    rst = rs; write = w; Data_in = d; read = r;
    ra = !rs && r && occ > 0;
    wa = !rs && w && (occ < DEPTH || ra);
`ifdef ROUTER_INPUT_FIFO_ERR_EN
    if (rs) begin e_ovf = 0; e_udf = 0; end
    else begin
      if (w && occ == DEPTH && !r) e_ovf = 1;
      if (r && occ == 0) e_udf = 1;
    end
`endif
    if (rs) begin
      exp_q.delete();
      occ = 0;
    end else begin
      occ = occ + int'(wa) - int'(ra);
      if (wa) exp_q.push_back(d);
    end
    @(posedge clk);
    #2;
    chk("count", 32'(count), 32'(occ));
    chk("empty", 32'(empty), 32'(occ == 0));
    chk("full", 32'(full), 32'(occ == DEPTH));
    chk("data_out", 32'(Data_out), occ == 0 ? 32'd0 : 32'(exp_q[0]));
`ifdef ROUTER_INPUT_FIFO_ERR_EN
    chk("ovf", 32'(ovf), 32'(e_ovf));
    chk("udf", 32'(udf), 32'(e_udf));
`endif
  endtask

  initial begin
    cycle(1, 0, 8'h00, 0);
    cycle(1, 0, 8'h00, 0);
    cycle(0, 0, 8'h00, 0);
    cycle(0, 1, 8'h35, 0);
    chk("fwft_data", 32'(Data_out), 32'h35);
    cycle(0, 0, 8'h00, 1);
    chk("fwft_empty", 32'(empty), 32'd1);
    for (int i = 1; i <= 4; i++) cycle(0, 1, 8'(i), 0);
    chk("fill_full", 32'(full), 32'd1);
    cycle(0, 1, 8'h05, 0);
    chk("drop_count", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) cycle(0, 0, 8'h00, 1);
    chk("drain_empty", 32'(empty), 32'd1);
    cycle(0, 0, 8'h00, 1);
    for (int i = 1; i <= 4; i++) cycle(0, 1, 8'(i), 0);
    cycle(0, 1, 8'hAA, 1);
    chk("simul_full", 32'(count), 32'd4);
    for (int i = 0; i < 4; i++) cycle(0, 0, 8'h00, 1);
    cycle(0, 1, 8'hC3, 1);
    chk("empty_wr_rd", 32'(count), 32'd1);
    cycle(0, 0, 8'h00, 1);
    for (int i = 0; i < 10; i++) begin
      cycle(0, 1, 8'(8'h10 + i), 0);
      cycle(0, 0, 8'h00, 1);
      cycle(0, 0, 8'h00, 0);
    end
    for (int i = 0; i < 3; i++) cycle(0, 1, 8'(8'h60 + i), 0);
    cycle(1, 1, 8'h77, 0);
    chk("midrst_empty", 32'(empty), 32'd1);
    cycle(0, 1, 8'h5A, 0);
    chk("post_rst_head", 32'(Data_out), 32'h5A);
    cycle(0, 0, 8'h00, 1);
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 59) == 0, $urandom_range(0, 2) != 0, 8'($urandom), $urandom_range(0, 1) == 1);
    cycle(0, 0, 8'h00, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
